uart_rx: RTL and testbench

UART receiver. It is the receive-side counterpart to the team's UART transmitter: 8N1 framing, idle-high line, LSB first.
- Oversamples the asynchronous rx line using a shared oversample tick.
- Validates the start bit at mid-bit.
- Shifts in DATA_BITS data bits and checks the stop bit.
- Presents each received word with a 1-cycle valid pulse, or flags a framing error.

---
 rtl/uart_rx.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver, single mid-bit sample per bit, oversample tick.
// Optional parity checking via UART_RX_PARITY_EN.            Revision: 1.0
// ----------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 os_tick,
  input  logic                 rx_line,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int            TW       = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int            BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  armed_q, armed_d;
`ifdef UART_RX_PARITY_EN
  logic                  par_q, par_d;
  logic                  perr_q, perr_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      armed_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_line;
      rx_s_q    <= rx_meta_q;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      armed_q   <= armed_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    armed_d = armed_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        tcnt_d = '0;
        bcnt_d = '0;
        if (rx_s_q) armed_d = 1'b1;
        // A line held low after a framing error must go high before re-arming.
        if (armed_q && !rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (os_tick) begin
          if (tcnt_q == HALF_M1) begin
            tcnt_d  = '0;
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (os_tick) begin
          if (tcnt_q == FULL_M1) begin
            tcnt_d  = '0;
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bcnt_q == LAST_BIT) begin
              bcnt_d  = '0;
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (os_tick) begin
          if (tcnt_q == FULL_M1) begin
            tcnt_d  = '0;
            par_d   = rx_s_q;
            state_d = S_STOP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (os_tick) begin
          if (tcnt_q == FULL_M1) begin
            tcnt_d  = '0;
            state_d = S_IDLE;
            if (rx_s_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_d  = (^{shift_q, par_q}) ^ PARITY_ODD;
`endif
            end else begin
              ferr_d  = 1'b1;
              armed_d = 1'b0;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// tb_uart_rx : directed frames into uart_rx with hand-computed expectations.
module tb_uart_rx;

  localparam int BIT_CLK = 64;   // 16 os_ticks x 4 clk per tick

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       os_tick = 1'b0;
  logic       rx_line = 1'b1;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  int         overlap_cnt = 0;
  int         busy_at_pulse = 0;
  int         quiet_fall = 0;
  logic       busy_prev = 1'b0;
  logic       last_perr = 1'b0;
  logic [7:0] rxq[$];

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .os_tick   (os_tick),
    .rx_line   (rx_line),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    int div = 0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      os_tick = (div == 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (valid) begin
        valid_cnt++;
        rxq.push_back(data_out);
        if (busy) busy_at_pulse++;
`ifdef UART_RX_PARITY_EN
        last_perr = parity_err;
`endif
      end
      if (frame_err) begin
        ferr_cnt++;
        if (busy) busy_at_pulse++;
      end
      if (valid && frame_err) overlap_cnt++;
      if (busy_prev && !busy && !valid && !frame_err) quiet_fall++;
      busy_prev = busy;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_line = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic idle(input int bits);
    rx_line = 1'b1;
    repeat (bits * BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input bit use_par, input logic par_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (use_par) send_bit(par_b);
    send_bit(stop_b);
  endtask

  initial begin
    int v0, f0, q0;
    logic [7:0] w;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_data", data_out, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // 1: 0xA5 with busy held across the frame
    v0 = valid_cnt; f0 = ferr_cnt; q0 = quiet_fall;
    w = 8'hA5;
    send_bit(1'b0);
    check("t1_busy_mid", busy, 1'b1);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
    send_bit(1'b1);
    check("t1_valid_cnt", valid_cnt - v0, 1);
    check("t1_data", data_out, 8'hA5);
    check("t1_ferr_cnt", ferr_cnt - f0, 0);
    check("t1_quiet_fall", quiet_fall - q0, 0);
    check("t1_busy_end", busy, 1'b0);
    idle(1);

    // 2: start glitch of 3 os_ticks is rejected
    v0 = valid_cnt; f0 = ferr_cnt; q0 = quiet_fall;
    rx_line = 1'b0;
    repeat (12) @(negedge clk);
    idle(2);
    check("t2_no_valid", valid_cnt - v0, 0);
    check("t2_no_ferr", ferr_cnt - f0, 0);
    check("t2_glitch_abort", quiet_fall - q0, 1);
    check("t2_busy", busy, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    check("t2_valid_cnt", valid_cnt - v0, 1);
    check("t2_data", data_out, 8'h5A);
    idle(1);

    // 3: framing error followed by a long break, then recovery
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (30 * BIT_CLK) @(negedge clk);
    check("t3_ferr_cnt", ferr_cnt - f0, 1);
    check("t3_no_valid", valid_cnt - v0, 0);
    check("t3_data_kept", data_out, 8'h5A);
    idle(2);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    check("t3_valid_cnt", valid_cnt - v0, 1);
    check("t3_data", data_out, 8'h81);
    check("t3_ferr_after", ferr_cnt - f0, 1);
    idle(1);

    // 4: back-to-back frames, no idle gap
    v0 = valid_cnt; q0 = rxq.size();
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    idle(1);
    check("t4_valid_cnt", valid_cnt - v0, 3);
    if (rxq.size() >= q0 + 3) begin
      check("t4_w0", rxq[q0],     8'h00);
      check("t4_w1", rxq[q0 + 1], 8'hFF);
      check("t4_w2", rxq[q0 + 2], 8'h55);
    end

    // 5: reset in the middle of 0xC3's data bits
    v0 = valid_cnt; f0 = ferr_cnt;
    w = 8'hC3;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(w[i]);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_rst_data", data_out, 8'h00);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_valid", valid, 1'b0);
    rx_line = 1'b1;
    rst_n = 1'b1;
    idle(12);
    check("t5_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 0);
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    check("t5_valid_cnt", valid_cnt - v0, 1);
    check("t5_data", data_out, 8'h12);
    idle(1);

`ifdef UART_RX_PARITY_EN
    // 6: even parity, good then bad parity bit
    v0 = valid_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    check("t6_valid_good", valid_cnt - v0, 1);
    check("t6_perr_good", last_perr, 1'b0);
    idle(1);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    check("t6_valid_bad", valid_cnt - v0, 2);
    check("t6_perr_bad", last_perr, 1'b1);
    check("t6_data", data_out, 8'h07);
    idle(1);
`endif

    check("overlap", overlap_cnt, 0);
    check("busy_at_pulse", busy_at_pulse, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
